// File: rtl/pattern_tx_pkg.sv
// Shared encodings for the serial pattern transmitter
// and its downstream "10010" detector bench.
package pattern_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [4:0] PAT_10010 = 5'b10010;

endpackage

// File: rtl/pattern_shreg.sv
// Loadable left-shift register, zero fill, MSB out.
// Load wins over shift when both are asserted.
module pattern_shreg #(
  parameter int W = 5
) (
  input  logic         ck,
  input  logic         rs,
  input  logic         ld,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic         msb
);

  logic [W-1:0] q;

  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (en) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

  assign msb = q[W-1];

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: MSB-first, N repetitions,
// optional zero gap between repetitions.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int             W       = 5,
  parameter logic [W-1:0]   PAT_DEF = PAT_10010,
  parameter int             CNT_W   = 4,
  parameter int             GAP     = 1
) (
  input  logic             ck,
  input  logic             rs,
  input  logic             start,
  input  logic             abort,
  input  logic [W-1:0]     pat,
  input  logic [CNT_W-1:0] rpt,
  output logic             s,
  output logic             sv,
  output logic             busy,
  output logic             done,
  output logic [1:0]       c
);

  localparam int BC_W = $clog2(W);
  localparam int GC_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BC_W-1:0] BC_TOP = BC_W'(W - 1);
  localparam logic [GC_W-1:0] GC_TOP =
    (GAP > 0) ? GC_W'(GAP - 1) : '0;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           st;
  logic [W-1:0]     pr;
  logic [BC_W-1:0]  bc;
  logic [CNT_W-1:0] rc;
  logic [GC_W-1:0]  gc;

  logic         ld;
  logic         en;
  logic [W-1:0] ld_d;
  logic         msb;

  // Reload from the shadow copy at each repetition boundary.
  assign ld =
    (st == ST_IDLE && start) ||
    (!abort && st == ST_SHIFT && bc == '0 &&
     rc > ONE && GAP == 0) ||
    (!abort && st == ST_GAP && gc == '0);
  assign en   = (st == ST_SHIFT) && !abort;
  assign ld_d = (st == ST_IDLE) ? pat : pr;

  pattern_shreg #(.W(W)) u_shreg (
    .ck  (ck),
    .rs  (rs),
    .ld  (ld),
    .en  (en),
    .d   (ld_d),
    .msb (msb)
  );

  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      st <= ST_IDLE;
      pr <= PAT_DEF;
      bc <= '0;
      rc <= '0;
      gc <= '0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (start) begin
            pr <= pat;
            rc <= (rpt == '0) ? ONE : rpt;
            bc <= BC_TOP;
            st <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            st <= ST_IDLE;
          end else if (bc == '0) begin
            if (rc > ONE) begin
              rc <= rc - ONE;
              if (GAP > 0) begin
                st <= ST_GAP;
                gc <= GC_TOP;
              end else begin
                bc <= BC_TOP;
              end
            end else begin
              st <= ST_DONE;
            end
          end else begin
            bc <= bc - BC_W'(1);
          end
        end
        ST_GAP: begin
          if (abort) begin
            st <= ST_IDLE;
          end else if (gc == '0) begin
            bc <= BC_TOP;
            st <= ST_SHIFT;
          end else begin
            gc <= gc - GC_W'(1);
          end
        end
        ST_DONE: st <= ST_IDLE;
      endcase
    end
  end

  assign s    = (st == ST_SHIFT) && msb;
  assign sv   = (st == ST_SHIFT);
  assign busy = (st == ST_SHIFT) || (st == ST_GAP);
  assign done = (st == ST_DONE);
  assign c    = st;

endmodule
